stage5_writeback: RTL and testbench

- Final pipeline stage, directly downstream of the memory stage; consumes the memory-to-writeback Axis stream.
- Selects the result for each instruction (ALU result, link value or extended load data) and drives the register-file write port through a registered interface.
- Counts retired instructions.
- Halts the pipeline on ECALL/EBREAK.

---
 rtl/stage5_writeback.sv | 91 +++++++++
 tb/tb_stage5_writeback.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/stage5_writeback.sv
// stage5_writeback: writeback stage (result select, registered RF write port, instret, ECALL/EBREAK halt); optional WB_BYPASS_EN forwarding path
module stage5_writeback #(
  parameter int REGISTER_WIDTH = 32,
  parameter int INSTRET_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      axis_memory_to_writeback_tvalid,
  output logic                      axis_memory_to_writeback_tready,
  input  logic [REGISTER_WIDTH-1:0] axis_memory_to_writeback_data_from_memory,
  input  logic [REGISTER_WIDTH-1:0] axis_memory_to_writeback_alu_result,
  input  logic [REGISTER_WIDTH-1:0] axis_memory_to_writeback_branch_target,
  input  logic [31:0]               axis_memory_to_writeback_decoded_instruction,
  output logic                      rf_write_enable,
  output logic [4:0]                rf_write_address,
  output logic [REGISTER_WIDTH-1:0] rf_write_data,
  output logic [INSTRET_WIDTH-1:0]  instret,
  output logic                      halted,
  output logic                      bypass_valid,
  output logic [4:0]                bypass_address,
  output logic [REGISTER_WIDTH-1:0] bypass_data
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  typedef enum logic {RUN, HALTED} state_t;
  state_t                    r_state;
  logic                      r_we;
  logic [4:0]                r_addr;
  logic [REGISTER_WIDTH-1:0] r_data;
  logic [INSTRET_WIDTH-1:0]  r_instret;
  logic [6:0]                w_opcode;
  logic [4:0]                w_rd;
  logic [2:0]                w_funct3;
  logic [REGISTER_WIDTH-1:0] w_dm;
  logic [REGISTER_WIDTH-1:0] w_load;
  logic [REGISTER_WIDTH-1:0] w_result;
  logic                      w_writes;
  logic                      w_accept;
  logic                      w_unused;
  assign w_opcode = axis_memory_to_writeback_decoded_instruction[6:0];
  assign w_rd     = axis_memory_to_writeback_decoded_instruction[11:7];
  assign w_funct3 = axis_memory_to_writeback_decoded_instruction[14:12];
  assign w_dm     = axis_memory_to_writeback_data_from_memory;
  assign w_unused = ^{axis_memory_to_writeback_branch_target, axis_memory_to_writeback_decoded_instruction[31:15]};
  assign w_load = w_funct3 == 3'b000 ? {{(REGISTER_WIDTH-8){w_dm[7]}}, w_dm[7:0]} :
                  w_funct3 == 3'b100 ? {{(REGISTER_WIDTH-8){1'b0}}, w_dm[7:0]} :
                  w_funct3 == 3'b001 ? {{(REGISTER_WIDTH-16){w_dm[15]}}, w_dm[15:0]} :
                  w_funct3 == 3'b101 ? {{(REGISTER_WIDTH-16){1'b0}}, w_dm[15:0]} : w_dm;
  assign w_writes = w_opcode inside {OP_LOAD, OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_JAL, OP_JALR};
  assign w_result = w_opcode == OP_LOAD ? w_load : axis_memory_to_writeback_alu_result;
  assign axis_memory_to_writeback_tready = r_state == RUN;
  assign w_accept = axis_memory_to_writeback_tvalid & axis_memory_to_writeback_tready;
  assign rf_write_enable  = r_we;
  assign rf_write_address = r_addr;
  assign rf_write_data    = r_data;
  assign instret          = r_instret;
  assign halted           = r_state == HALTED;
  // Retire accepted instructions: write port, counter and halt on ECALL/EBREAK
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RUN;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_instret <= '0;
    end else begin
      r_we <= w_accept & w_writes & (w_rd != 5'd0);
      if (w_accept) begin
        r_addr    <= w_rd;
        r_data    <= w_result;
        r_instret <= r_instret + 1'b1;
        if (w_opcode == OP_SYSTEM && w_funct3 == 3'b000) r_state <= HALTED;
      end
    end
  end
`ifdef WB_BYPASS_EN
  assign bypass_valid   = w_accept & w_writes & (w_rd != 5'd0);
  assign bypass_address = w_rd;
  assign bypass_data    = w_result;
`else
  assign bypass_valid   = 1'b0;
  assign bypass_address = '0;
  assign bypass_data    = '0;
`endif
endmodule

// File: tb/tb_stage5_writeback.sv
// tb_stage5_writeback: randomized + directed checks of stage5_writeback against a behavioural model
module tb_stage5_writeback;
  localparam logic [6:0] OP_LOAD = 7'h03, OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_IMM = 7'h13,
    OP_REG = 7'h33, OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_STORE = 7'h23, OP_BRANCH = 7'h63,
    OP_SYSTEM = 7'h73, OP_FENCE = 7'h0F;
  logic clk = 0, rst = 1, tvalid = 0;
  logic [31:0] ins = 0, dm = 0, alu = 0, bt = 0;
  logic tready, we, halted, bv;
  logic [4:0] addr, ba;
  logic [31:0] data, bd;
  logic [63:0] instret;
  logic [7:0] instret8;
  logic u_tready_unused, u_we_unused, u_halted_unused, u_bv_unused;
  logic [4:0] u_addr_unused, u_ba_unused;
  logic [31:0] u_data_unused, u_bd_unused;
  int n_tests = 0, n_fail = 0;
  logic m_we = 0, m_halted = 0;
  logic [4:0] m_addr = 0;
  logic [31:0] m_data = 0;
  logic [63:0] m_instret = 0;
  always #5 clk = ~clk;
  stage5_writeback dut (
    .clk(clk), .rst(rst),
    .axis_memory_to_writeback_tvalid(tvalid), .axis_memory_to_writeback_tready(tready),
    .axis_memory_to_writeback_data_from_memory(dm), .axis_memory_to_writeback_alu_result(alu),
    .axis_memory_to_writeback_branch_target(bt), .axis_memory_to_writeback_decoded_instruction(ins),
    .rf_write_enable(we), .rf_write_address(addr), .rf_write_data(data), .instret(instret),
    .halted(halted), .bypass_valid(bv), .bypass_address(ba), .bypass_data(bd));
  stage5_writeback #(.INSTRET_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .axis_memory_to_writeback_tvalid(tvalid), .axis_memory_to_writeback_tready(u_tready_unused),
    .axis_memory_to_writeback_data_from_memory(dm), .axis_memory_to_writeback_alu_result(alu),
    .axis_memory_to_writeback_branch_target(bt), .axis_memory_to_writeback_decoded_instruction(ins),
    .rf_write_enable(u_we_unused), .rf_write_address(u_addr_unused), .rf_write_data(u_data_unused),
    .instret(instret8), .halted(u_halted_unused), .bypass_valid(u_bv_unused),
    .bypass_address(u_ba_unused), .bypass_data(u_bd_unused));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
    return {17'd0, f3, rd, op};
  endfunction
  function automatic logic writes(input logic [31:0] i);
    return i[6:0] inside {OP_LOAD, OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_JAL, OP_JALR};
  endfunction
  function automatic logic [31:0] result(input logic [31:0] i, input logic [31:0] d, input logic [31:0] a);
    if (i[6:0] != OP_LOAD) return a;
    case (i[14:12])
      3'd0: return int'($signed(d[7:0]));
      3'd1: return int'($signed(d[15:0]));
      3'd4: return d & 32'hFF;
      3'd5: return d & 32'hFFFF;
      default: return d;
    endcase
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      m_we <= 0; m_addr <= 0; m_data <= 0; m_instret <= 0; m_halted <= 0;
    end else begin
      m_we <= tvalid && !m_halted && writes(ins) && ins[11:7] != 0;
      if (tvalid && !m_halted) begin
        m_instret <= m_instret + 1;
        m_addr <= ins[11:7];
        m_data <= result(ins, dm, alu);
        if (ins[6:0] == OP_SYSTEM && ins[14:12] == 0) m_halted <= 1;
      end
    end
  end
  always @(negedge clk) begin
    chk("we", we, m_we);
    if (m_we) begin
      chk("addr", addr, m_addr);
      chk("data", data, m_data);
    end
    chk("instret", instret, m_instret);
    chk("instret8", instret8, {56'd0, m_instret[7:0]});
    chk("halted", halted, m_halted);
    chk("tready", tready, !m_halted);
`ifdef WB_BYPASS_EN
    chk("bypass_valid", bv, tvalid && !m_halted && writes(ins) && ins[11:7] != 0);
    if (bv) begin
      chk("bypass_addr", ba, ins[11:7]);
      chk("bypass_data", bd, result(ins, dm, alu));
    end
`else
    chk("bypass_zero", {bv, ba, bd}, 0);
`endif
  end
  task automatic cyc(input logic v, input logic [31:0] i, input logic [31:0] d, input logic [31:0] a);
    tvalid = v; ins = i; dm = d; alu = a;
    @(posedge clk); #1;
  endtask
  logic [6:0] ops [11] = '{OP_LOAD, OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_JAL, OP_JALR,
                           OP_STORE, OP_BRANCH, OP_SYSTEM, OP_FENCE};
  initial begin
    logic [31:0] r;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    rst = 0;
    chk("rst_we", we, 0); chk("rst_instret", instret, 0); chk("rst_halted", halted, 0); chk("rst_tready", tready, 1);
    cyc(1, mk(OP_IMM, 5, 0), 0, 32'h1234);
    chk("imm_we", we, 1); chk("imm_addr", addr, 5); chk("imm_data", data, 32'h1234); chk("imm_instret", instret, 1);
    cyc(0, 0, 0, 0);
    chk("idle_we", we, 0);
    cyc(1, mk(OP_LOAD, 3, 0), 32'hAABBCC80, 0); chk("lb", data, 32'hFFFFFF80);
    cyc(1, mk(OP_LOAD, 3, 4), 32'hAABBCC80, 0); chk("lbu", data, 32'h00000080);
    cyc(1, mk(OP_LOAD, 3, 1), 32'h00008001, 0); chk("lh", data, 32'hFFFF8001);
    cyc(1, mk(OP_LOAD, 3, 5), 32'h00008001, 0); chk("lhu", data, 32'h00008001);
    tvalid = 1; ins = mk(OP_LOAD, 7, 0); dm = 32'h80; alu = 0;
    #2;
`ifdef WB_BYPASS_EN
    chk("byp_valid", bv, 1); chk("byp_addr", ba, 7); chk("byp_data", bd, 32'hFFFFFF80);
`else
    chk("byp_off", {bv, ba, bd}, 0);
`endif
    @(posedge clk); #1;
    cyc(1, mk(OP_REG, 0, 0), 0, 32'hDEADBEEF); chk("rd0_we", we, 0); chk("rd0_instret", instret, 7);
    cyc(1, mk(OP_STORE, 4, 2), 0, 1); chk("store_we", we, 0);
    cyc(1, mk(OP_BRANCH, 4, 0), 0, 1); chk("branch_we", we, 0); chk("branch_instret", instret, 9);
    rst = 1; cyc(0, 0, 0, 0); rst = 0;
    for (int k = 1; k <= 4; k++) begin
      cyc(1, mk(OP_IMM, 5'(k), 0), 0, 32'(k * 16));
      chk("b2b_we", we, 1); chk("b2b_addr", addr, 5'(k)); chk("b2b_data", data, 32'(k * 16));
    end
    chk("b2b_instret", instret, 4);
    cyc(1, mk(OP_SYSTEM, 0, 0), 0, 0);
    chk("ecall_instret", instret, 5); chk("ecall_halted", halted, 1); chk("ecall_tready", tready, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, mk(OP_IMM, 6, 0), 0, 32'h55);
      chk("held_we", we, 0); chk("held_instret", instret, 5);
    end
    rst = 1; cyc(1, mk(OP_IMM, 9, 0), 0, 32'h77); rst = 0;
    chk("rstacc_we", we, 0); chk("rstacc_instret", instret, 0); chk("rstacc_halted", halted, 0); chk("rstacc_tready", tready, 1);
    for (int k = 0; k < 256; k++) cyc(1, mk(OP_IMM, 1, 0), 0, 32'(k));
    chk("wrap_instret8", instret8, 0); chk("wrap_instret", instret, 256);
    for (int c = 0; c < 4000; c++) begin
      r = $urandom;
      rst = (m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0;
      tvalid = $urandom_range(0, 9) < 7;
      ins = {r[31:15], 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             ops[$urandom_range(0, 10)]};
      dm = $urandom; alu = $urandom; bt = $urandom;
      @(posedge clk); #1;
    end
    rst = 0; tvalid = 0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
